// File: rtl/apb4_crc_gen_if.sv
// apb4_crc_gen_if: APB4 bus bundle between a master and the CRC generator slave.
interface apb4_crc_gen_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_crc_gen.sv
// apb4_crc_gen: APB4 configurable CRC generator with input FIFO, one byte per cycle.
// Optional interrupt output enabled by defining CRC_IRQ_EN.
module apb4_crc_gen #(
    parameter int CRC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          pclk,
    input  logic          preset,
    apb4_crc_gen_if.slave apb,
    output logic          irq_o
);
    localparam int CW = CRC_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, CALC} state_t;

    state_t        state_q, state_d;
    logic          en_q, en_d, revin_q, revin_d, revout_q, revout_d;
    logic [1:0]    size_q, size_d, bsz_q, bsz_d, cnt_q, cnt_d;
    logic [4:0]    width_q, width_d;
    logic [CW-1:0] poly_q, poly_d, init_q, init_d, xorv_q, xorv_d, acc_q, acc_d;
    logic          done_q, done_d, ovf_q, ovf_d;
    logic [31:0]   word_q, word_d;
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [33:0]   mem_q [FIFO_DEPTH];
    logic [33:0]   mem_d [FIFO_DEPTH];

    logic          xfer, wr, rd, busy, empty, full, locked;
    logic          ctrl_wr, ctrl_ok, cfg_wr, cfg_ok, push_req, push, drop, abort, stat_rd;
    logic          pop, done_set;
    logic [3:0]    idx;
    logic [5:0]    w_raw, w;
    logic [CW-1:0] mask, msb, step, acc_m, acc_r, res, wd;
    logic [7:0]    byte_r, din;
    logic [31:0]   rdata;
    logic          ie_q;
    logic          unused_ok;

    assign xfer     = apb.psel && apb.penable;
    assign wr       = xfer && apb.pwrite;
    assign rd       = xfer && !apb.pwrite;
    assign idx      = apb.paddr[5:2];
    assign wd       = apb.pwdata[CW-1:0];
    assign busy     = state_q == CALC;
    assign empty    = wp_q == rp_q;
    assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign locked   = busy || !empty;
    assign ctrl_wr  = wr && idx == 4'd0;
    assign ctrl_ok  = ctrl_wr && (!apb.pwdata[0] || !locked);
    assign cfg_wr   = wr && (idx == 4'd1 || idx == 4'd2 || idx == 4'd3);
    assign cfg_ok   = cfg_wr && !locked;
    assign push_req = wr && idx == 4'd4 && en_q;
    assign push     = push_req && !full;
    assign drop     = push_req && full;
    assign abort    = ctrl_ok && !apb.pwdata[0];
    assign stat_rd  = rd && idx == 4'd5;
    assign unused_ok = ^{apb.paddr[11:6], apb.paddr[1:0]};

    // Out-of-range active widths fall back to the full CRC_WIDTH
    assign w_raw = {1'b0, width_q} + 6'd1;
    assign w     = (w_raw > 6'(CW) || w_raw < 6'd8) ? 6'(CW) : w_raw;
    assign mask  = {CW{1'b1}} >> (6'(CW) - w);
    assign msb   = mask ^ (mask >> 1);

    assign byte_r = {<<{word_q[31:24]}};
    assign din    = revin_q ? byte_r : word_q[31:24];

    always_comb begin
        step = acc_q;
        for (int i = 0; i < 8; i++)
            step = ((step << 1) & mask) ^ (((|(step & msb)) ^ din[7 - i]) ? poly_q & mask : '0);
    end

    // Reversing the masked accumulator then shifting right reflects only the low w bits
    assign acc_m = acc_q & mask;
    assign acc_r = {<<{acc_m}};
    assign res   = ((revout_q ? acc_r >> (6'(CW) - w) : acc_q) ^ xorv_q) & mask;

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        revin_d  = revin_q;
        revout_d = revout_q;
        size_d   = size_q;
        width_d  = width_q;
        poly_d   = poly_q;
        init_d   = init_q;
        xorv_d   = xorv_q;
        acc_d    = acc_q;
        word_d   = word_q;
        bsz_d    = bsz_q;
        cnt_d    = cnt_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        mem_d    = mem_q;
        pop      = 1'b0;
        done_set = 1'b0;
        if (ctrl_ok) begin
            en_d     = apb.pwdata[0];
            revin_d  = apb.pwdata[1];
            revout_d = apb.pwdata[2];
            size_d   = apb.pwdata[4:3];
            width_d  = apb.pwdata[9:5];
            if (apb.pwdata[0] && !en_q) acc_d = init_q;
        end
        if (cfg_ok) begin
            poly_d = idx == 4'd1 ? wd : poly_q;
            xorv_d = idx == 4'd3 ? wd : xorv_q;
            init_d = idx == 4'd2 ? wd : init_q;
            acc_d  = idx == 4'd2 ? wd : acc_d;
        end
        if (state_q == IDLE) begin
            pop     = !empty;
            state_d = empty ? IDLE : CALC;
        end else begin
            acc_d  = step;
            word_d = word_q << 8;
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == bsz_q) begin
                pop      = !empty;
                done_set = empty;
                state_d  = empty ? IDLE : CALC;
            end
        end
        if (pop) begin
            word_d = mem_q[rp_q[AW-1:0]][33:2];
            bsz_d  = mem_q[rp_q[AW-1:0]][1:0];
            cnt_d  = 2'd0;
            rp_d   = rp_q + 1'b1;
        end
        if (push) begin
            mem_d[wp_q[AW-1:0]] = {apb.pwdata, size_q};
            wp_d = wp_q + 1'b1;
        end
        done_d = (done_q && !stat_rd) || done_set;
        ovf_d  = (ovf_q && !stat_rd) || drop;
        if (abort) begin
            state_d = IDLE;
            acc_d   = acc_q;
            rp_d    = wp_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            revin_q  <= 1'b0;
            revout_q <= 1'b0;
            size_q   <= '0;
            width_q  <= '0;
            poly_q   <= '0;
            init_q   <= '0;
            xorv_q   <= '0;
            acc_q    <= '0;
            word_q   <= '0;
            bsz_q    <= '0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            revin_q  <= revin_d;
            revout_q <= revout_d;
            size_q   <= size_d;
            width_q  <= width_d;
            poly_q   <= poly_d;
            init_q   <= init_d;
            xorv_q   <= xorv_d;
            acc_q    <= acc_d;
            word_q   <= word_d;
            bsz_q    <= bsz_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

`ifdef CRC_IRQ_EN
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) ie_q <= 1'b0;
        else if (ctrl_ok) ie_q <= apb.pwdata[10];
    end
    assign irq_o = ie_q && (done_q || ovf_q);
`else
    assign ie_q  = 1'b0;
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata = idx == 4'd0 ? {21'b0, ie_q, width_q, size_q, revout_q, revin_q, en_q} :
                idx == 4'd1 ? 32'(poly_q) :
                idx == 4'd2 ? 32'(init_q) :
                idx == 4'd3 ? 32'(xorv_q) :
                idx == 4'd5 ? {27'b0, ovf_q, empty, full, busy, done_q} :
                idx == 4'd6 ? 32'(res) : 32'b0;
    end

    assign apb.prdata  = (apb.psel && !apb.pwrite) ? rdata : 32'b0;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = xfer && (idx > 4'd6 || (ctrl_wr && !ctrl_ok) || (cfg_wr && !cfg_ok));
endmodule
